instr_fetch_seq: RTL and testbench
==================================

Name: instr_fetch_seq

Overview:
Instruction fetch and PC sequencer that produces the instruction word, and its opcode field, consumed by the single-cycle control decoder. It takes back the decoder's Jump/Branch/Beq outputs plus the ALU Zero flag to compute the next PC. It sits between instruction memory, reached through a req/ack handshake, and the decode/execute datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 255, maximum consecutive un-acked FETCH cycles before the error state (legal range 1..255; the counter is 8 bits).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_req  out  1  instruction memory read request.
imem_addr  out  32  read address; equals pc.
imem_ack  in  1  read data valid; qualified by imem_req.
imem_rdata  in  32  instruction word.
instr  out  32  registered instruction.
opcode  out  6  instr[31:26], to the control decoder.
instr_valid  out  1  instr is being executed this cycle.
stall  in  1  datapath hold request while in EXEC.
Jump  in  1  from decoder.
Branch  in  1  from decoder.
Beq  in  1  1 = branch when equal (Zero), 0 = branch when not equal.
Zero  in  1  ALU zero flag.
pc  out  32  current PC.
pc_plus4  out  32  pc + 4, modulo 2^32.
instr_count  out  32  retired-instruction counter; wraps.
fetch_err  out  1  sticky timeout error.

Behaviour:
- Reset is asynchronous and active-low. While rst_n = 0: pc = RESET_PC, instr = 0, instr_valid = 0, imem_req = 0, instr_count = 0, fetch_err = 0, timeout counter = 0, state = FETCH.
- Reset mid-request drops imem_req immediately. An ack arriving while reset is held is ignored. After release, fetch restarts at RESET_PC.
- States: FETCH, EXEC, ERROR. All are registered.
- FETCH:
  - imem_req = 1 and imem_addr = pc, both stable until ack.
  - On a cycle with imem_req & imem_ack: instr <= imem_rdata, timeout counter <= 0, next state EXEC.
  - Otherwise the counter increments.
  - If the TIMEOUT-th consecutive cycle ends without ack, next state is ERROR. An ack in that TIMEOUT-th cycle is accepted, so ack wins.
  - An ack seen outside FETCH is ignored.
- EXEC:
  - instr_valid = 1 and imem_req = 0.
  - If stall = 1: remain in EXEC; pc, instr and instr_count are held.
  - If stall = 0:
    - taken = Branch & (Beq ? Zero : ~Zero).
    - If Jump = 1: pc <= {pc_plus4[31:28], instr[25:0], 2'b00}. Jump has priority over Branch.
    - Else if taken: pc <= pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}, modulo 2^32.
    - Else: pc <= pc_plus4.
    - instr_count increments by 1 and wraps at 2^32 to 0.
    - Next state FETCH.
- Control inputs are sampled only on the non-stalled EXEC cycle.
- ERROR:
  - fetch_err = 1, imem_req = 0, instr_valid = 0, pc frozen.
  - Exit only by reset.
- Minimum latency: 2 cycles per instruction (ack in the first FETCH cycle, then one EXEC cycle).
- opcode is combinational from the instr register. pc_plus4 is combinational from pc.
- pc is not forced word-aligned. Alignment is the responsibility of RESET_PC and of the targets.

Test Plan:
1. Reset with RESET_PC = 0, then ack in the first FETCH cycle with rdata = 32'h20080005 -> imem_req high 1 cycle; next cycle instr_valid = 1 and opcode = 6'h08; after EXEC pc = 4, imem_addr = 4, instr_count = 1.
2. Branch at pc = 0x10, instr = 32'h1109FFFC:
   - Branch=1, Beq=1, Zero=1 -> pc = 0x04.
   - Branch=1, Beq=1, Zero=0 -> pc = 0x14.
   - Branch=1, Beq=0, Zero=0 -> pc = 0x04.
3. Jump at pc = 0x40000010, instr = 32'h08000100, Jump=1 -> pc = 0x40000400. The same with Branch=1, Beq=1, Zero=1 -> still 0x40000400.
4. stall held 3 cycles in EXEC -> instr_valid high 4 cycles, imem_req low throughout, pc unchanged until the 4th cycle, instr_count increments exactly once.
5. TIMEOUT = 8, no ack -> imem_req high exactly 8 cycles, then fetch_err = 1 and imem_req = 0, held indefinitely. Repeat with ack on the 8th cycle -> accepted, no error.
6. Ack delayed 3 cycles, rst_n pulsed low in the 2nd FETCH cycle -> imem_req drops asynchronously, pc = RESET_PC, late ack ignored; after release, FETCH restarts at RESET_PC with instr_count = 0.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq
// ---------------
// Instruction fetch and PC sequencer for a single-cycle core. It fetches a
// word from instruction memory through a req/ack handshake and holds it in
// the instr register while the decode/execute datapath works on it. It then
// uses the decoder's Jump/Branch/Beq outputs and the ALU Zero flag to select
// the next PC.
//
// Each instruction runs FETCH (one or more cycles, waiting for ack) and then
// EXEC (one or more cycles, extended by stall). If instruction memory never
// answers, TIMEOUT consecutive un-acked fetch cycles move the sequencer into
// a sticky ERROR state. Only reset leaves ERROR.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   instruction memory read request (FETCH only)
//   imem_addr    out  32  read address, always equal to pc
//   imem_ack     in   1   read data valid, honoured only while imem_req is high
//   imem_rdata   in   32  instruction word from memory
//   instr        out  32  registered instruction
//   opcode       out  6   instr[31:26], to the control decoder
//   instr_valid  out  1   instr is being executed this cycle (EXEC)
//   stall        in   1   datapath hold request while in EXEC
//   Jump         in   1   decoder: jump
//   Branch       in   1   decoder: conditional branch
//   Beq          in   1   1 = branch on Zero, 0 = branch on not Zero
//   Zero         in   1   ALU zero flag
//   pc           out  32  current PC
//   pc_plus4     out  32  pc + 4 (wraps modulo 2^32)
//   instr_count  out  32  retired-instruction counter (wraps)
//   fetch_err    out  1   sticky fetch timeout error

module instr_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Beq,
  input  logic        Zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    ERROR = 2'd2
  } state_t;

  // Value of the timeout counter during the last fetch cycle allowed
  // without an ack.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  tmo_cnt, tmo_cnt_next;
  logic [31:0] pc_next, instr_next, count_next;
  logic [31:0] branch_off;
  logic        taken;

  // State decodes the outputs directly. The request is also gated by rst_n,
  // so it drops the moment reset is asserted. Without that gate, the reset
  // state (FETCH) would keep the request high.
  assign imem_req    = rst_n & (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign fetch_err   = (state == ERROR);
  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;
  assign opcode      = instr[31:26];

  // Next-state and next-datapath logic. The control inputs are only looked at
  // in a non-stalled EXEC cycle. An ack outside FETCH has no effect. When an
  // ack arrives in the final allowed fetch cycle, it takes priority over the
  // timeout.
  always_comb begin
    state_next   = state;
    tmo_cnt_next = tmo_cnt;
    pc_next      = pc;
    instr_next   = instr;
    count_next   = instr_count;
    taken        = Branch & (Beq ? Zero : ~Zero);
    branch_off   = {{14{instr[15]}}, instr[15:0], 2'b00};

    case (state)
      FETCH: begin
        if (imem_req && imem_ack) begin
          instr_next   = imem_rdata;
          tmo_cnt_next = 8'd0;
          state_next   = EXEC;
        end else begin
          tmo_cnt_next = tmo_cnt + 8'd1;
          if (tmo_cnt == TMO_LAST) begin
            state_next = ERROR;
          end
        end
      end
      EXEC: begin
        if (!stall) begin
          if (Jump) begin
            pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
          end else if (taken) begin
            pc_next = pc_plus4 + branch_off;
          end else begin
            pc_next = pc_plus4;
          end
          count_next = instr_count + 32'd1;
          state_next = FETCH;
        end
      end
      ERROR: begin
        state_next = ERROR;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: PC, instruction, retire counter and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_count <= 32'd0;
      tmo_cnt     <= 8'd0;
    end else begin
      pc          <= pc_next;
      instr       <= instr_next;
      instr_count <= count_next;
      tmo_cnt     <= tmo_cnt_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq
// ------------------
// Directed self-checking bench for instr_fetch_seq. The DUT uses
// RESET_PC = 0 and TIMEOUT = 8. Inputs change on the falling edge, and
// outputs are sampled on the falling edge. Every expected value is a
// hand-computed constant.

module tb_instr_fetch_seq;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        stall;
  logic        Jump;
  logic        Branch;
  logic        Beq;
  logic        Zero;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr_count;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  instr_fetch_seq #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .opcode     (opcode),
    .instr_valid(instr_valid),
    .stall      (stall),
    .Jump       (Jump),
    .Branch     (Branch),
    .Beq        (Beq),
    .Zero       (Zero),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr_count(instr_count),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helper, called at a falling edge while in FETCH. It acks
  // immediately with word w, runs a single non-stalled EXEC cycle with the
  // given controls, and returns at the falling edge of the next FETCH cycle.
  task automatic do_instr(input logic [31:0] w, input logic j, input logic b,
                          input logic beq, input logic z);
    imem_ack = 1'b1; imem_rdata = w;
    @(negedge clk);
    imem_ack = 1'b0; stall = 1'b0; Jump = j; Branch = b; Beq = beq; Zero = z;
    @(negedge clk);
    Jump = 1'b0; Branch = 1'b0; Beq = 1'b0; Zero = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    Jump = 1'b0; Branch = 1'b0; Beq = 1'b0; Zero = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc: got %h want %h", pc, 32'h0); end
    checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr: got %h want %h", instr, 32'h0); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b want 0", instr_valid); end
    checks++; if (instr_count !== 32'h0) begin errors++; $display("[TB] FAIL rst_count: got %h want 0", instr_count); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b want 0", fetch_err); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_rel_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_rel_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_first_fetch;
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL ff_req_exec: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL ff_valid: got %b want 1", instr_valid); end
    checks++; if (opcode !== 6'h08) begin errors++; $display("[TB] FAIL ff_opcode: got %h want 08", opcode); end
    checks++; if (instr !== 32'h2008_0005) begin errors++; $display("[TB] FAIL ff_instr: got %h want 20080005", instr); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("[TB] FAIL ff_pc_plus4: got %h want 4", pc_plus4); end
    @(negedge clk);
    checks++; if (pc !== 32'h4) begin errors++; $display("[TB] FAIL ff_pc: got %h want 4", pc); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL ff_addr: got %h want 4", imem_addr); end
    checks++; if (instr_count !== 32'd1) begin errors++; $display("[TB] FAIL ff_count: got %0d want 1", instr_count); end
    checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL ff_back_fetch: got req=%b valid=%b want req=1 valid=0", imem_req, instr_valid); end
  endtask

  task automatic test_branch;
    // Jump to 0x10: instr[25:0] = 4.
    do_instr(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (pc !== 32'h10) begin errors++; $display("[TB] FAIL br_setup_pc: got %h want 10", pc); end
    do_instr(32'h1109_FFFC, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (pc !== 32'h04) begin errors++; $display("[TB] FAIL br_beq_taken: got %h want 04", pc); end
    do_instr(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0);
    do_instr(32'h1109_FFFC, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (pc !== 32'h14) begin errors++; $display("[TB] FAIL br_beq_not_taken: got %h want 14", pc); end
    do_instr(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0);
    do_instr(32'h1109_FFFC, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (pc !== 32'h04) begin errors++; $display("[TB] FAIL br_bne_taken: got %h want 04", pc); end
    do_instr(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0);
    do_instr(32'h1109_FFFC, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if (pc !== 32'h14) begin errors++; $display("[TB] FAIL br_bne_not_taken: got %h want 14", pc); end
    do_instr(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0);
    do_instr(32'h1109_FFFC, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (pc !== 32'h14) begin errors++; $display("[TB] FAIL br_no_branch: got %h want 14", pc); end
    // 1 + 10 instructions retired so far.
    checks++; if (instr_count !== 32'd11) begin errors++; $display("[TB] FAIL br_count: got %0d want 11", instr_count); end
  endtask

  task automatic test_jump;
    // Climb through the 256 MB regions. Each jump at xFFFFFFC picks up the
    // next region from pc_plus4[31:28].
    do_instr(32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (pc !== 32'h0FFF_FFFC) begin errors++; $display("[TB] FAIL jmp_r0: got %h want 0ffffffc", pc); end
    checks++; if (pc_plus4 !== 32'h1000_0000) begin errors++; $display("[TB] FAIL jmp_pc_plus4: got %h want 10000000", pc_plus4); end
    do_instr(32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (pc !== 32'h1FFF_FFFC) begin errors++; $display("[TB] FAIL jmp_r1: got %h want 1ffffffc", pc); end
    do_instr(32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    do_instr(32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (pc !== 32'h3FFF_FFFC) begin errors++; $display("[TB] FAIL jmp_r3: got %h want 3ffffffc", pc); end
    do_instr(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (pc !== 32'h4000_0010) begin errors++; $display("[TB] FAIL jmp_to_40000010: got %h want 40000010", pc); end
    do_instr(32'h0800_0100, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (pc !== 32'h4000_0400) begin errors++; $display("[TB] FAIL jmp_plain: got %h want 40000400", pc); end
    do_instr(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0);
    do_instr(32'h0800_0100, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (pc !== 32'h4000_0400) begin errors++; $display("[TB] FAIL jmp_over_branch: got %h want 40000400", pc); end
    checks++; if (instr_count !== 32'd19) begin errors++; $display("[TB] FAIL jmp_count: got %0d want 19", instr_count); end
  endtask

  task automatic test_stall;
    // Runs at pc 0x40000400 with a nop and instr_count 19. A jump is
    // requested during the stalled cycles and must be ignored.
    imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_hs_c%0d: got valid=%b req=%b want valid=1 req=0", i, instr_valid, imem_req); end
      checks++; if (pc !== 32'h4000_0400 || instr_count !== 32'd19) begin errors++; $display("[TB] FAIL stall_hold_c%0d: got pc=%h count=%0d want pc=40000400 count=19", i, pc, instr_count); end
      stall = (i < 3);
      Jump  = (i < 3);
      @(negedge clk);
    end
    stall = 1'b0; Jump = 1'b0;
    checks++; if (pc !== 32'h4000_0404) begin errors++; $display("[TB] FAIL stall_pc_after: got %h want 40000404", pc); end
    checks++; if (instr_count !== 32'd20) begin errors++; $display("[TB] FAIL stall_count_after: got %0d want 20", instr_count); end
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL stall_exit: got valid=%b req=%b want valid=0 req=1", instr_valid, imem_req); end
  endtask

  task automatic test_timeout;
    int n;
    // An ack in the 8th (last allowed) fetch cycle is accepted.
    for (int i = 1; i <= 8; i++) begin
      checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_wait_c%0d: got req=%b err=%b want req=1 err=0", i, imem_req, fetch_err); end
      if (i == 8) begin imem_ack = 1'b1; imem_rdata = 32'h0000_0000; end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_last_ack: got valid=%b err=%b want valid=1 err=0", instr_valid, fetch_err); end
    @(negedge clk);
    checks++; if (pc !== 32'h4000_0408) begin errors++; $display("[TB] FAIL tmo_last_pc: got %h want 40000408", pc); end
    // No ack at all: exactly 8 request cycles, then a sticky error.
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (imem_req === 1'b1) n++;
      @(negedge clk);
    end
    checks++; if (n !== 8) begin errors++; $display("[TB] FAIL tmo_req_cycles: got %0d want 8", n); end
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL tmo_error: got err=%b req=%b valid=%b want 1 0 0", fetch_err, imem_req, instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    repeat (5) @(negedge clk);
    imem_ack = 1'b0;
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h4000_0408) begin errors++; $display("[TB] FAIL tmo_sticky: got err=%b req=%b pc=%h want 1 0 40000408", fetch_err, imem_req, pc); end
    checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL tmo_ack_ignored: got %h want 0", instr); end
  endtask

  task automatic test_reset_mid_fetch;
    // Leave ERROR by reset, then retire one nop so that pc and count are
    // not at their reset values.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rmf_recover: got err=%b req=%b want 0 1", fetch_err, imem_req); end
    do_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (imem_addr !== 32'h4 || instr_count !== 32'd1) begin errors++; $display("[TB] FAIL rmf_setup: got addr=%h count=%0d want 4 1", imem_addr, instr_count); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rmf_req_async: got %b want 0", imem_req); end
    checks++; if (pc !== 32'h0 || instr_count !== 32'd0) begin errors++; $display("[TB] FAIL rmf_async_clear: got pc=%h count=%0d want 0 0", pc, instr_count); end
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmf_late_ack: got instr=%h valid=%b want 0 0", instr, instr_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_count !== 32'd0) begin errors++; $display("[TB] FAIL rmf_restart: got req=%b addr=%h count=%0d want 1 0 0", imem_req, imem_addr, instr_count); end
    do_instr(32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (pc !== 32'h4 || instr_count !== 32'd1 || instr !== 32'h2008_0005) begin errors++; $display("[TB] FAIL rmf_after: got pc=%h count=%0d instr=%h want 4 1 20080005", pc, instr_count, instr); end
  endtask

  initial begin
    test_reset;
    test_first_fetch;
    test_branch;
    test_jump;
    test_stall;
    test_timeout;
    test_reset_mid_fetch;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
